// File: rtl/fm_stream_tx.sv
// Purpose: feeds one optional parameter load and one feature-map frame (VS pulse, rows, blanking) to a layer input port.
// Latency: a source word accepted in cycle t appears on the layer-side outputs in cycle t+1; done pulses one cycle after the last pixel.
// Backpressure: source ready is high only in PARA/ROW, and source stalls hold counters and outputs; the layer side cannot stall.
module fm_stream_tx #(
  parameter int FM_DEPTH   = 64,
  parameter int FM_WIDTH   = 56,
  parameter int FM_HEIGHT  = 56,
  parameter int DATA_WIDTH = 16,
  parameter int PARA_WIDTH = 16,
  parameter int PARA_WORDS = 704,
  parameter int VS_LEAD    = 4,
  parameter int HBLANK     = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         cfg_load,
  input  logic                         para_src_valid,
  output logic                         para_src_ready,
  input  logic signed [PARA_WIDTH-1:0] para_src_data,
  input  logic                         pix_src_valid,
  output logic                         pix_src_ready,
  input  logic signed [DATA_WIDTH-1:0] pix_src_data [FM_DEPTH-1:0],
  output logic                         mode_out,
  output logic                         verticle_sync,
  output logic                         data_out_valid,
  output logic signed [DATA_WIDTH-1:0] data_out [FM_DEPTH-1:0],
  output logic signed [PARA_WIDTH-1:0] para_out,
  output logic                         busy,
  output logic                         done
);

  // Counter widths; a minimum of one bit keeps degenerate sizes legal.
  localparam int CW      = (FM_WIDTH   > 1) ? $clog2(FM_WIDTH)   : 1;
  localparam int RW      = (FM_HEIGHT  > 1) ? $clog2(FM_HEIGHT)  : 1;
  localparam int PW      = (PARA_WORDS > 1) ? $clog2(PARA_WORDS) : 1;
  localparam int BLK_MAX = (VS_LEAD > HBLANK) ? VS_LEAD : HBLANK;
  localparam int BW      = (BLK_MAX    > 1) ? $clog2(BLK_MAX)    : 1;

  localparam logic [CW-1:0] COL_LAST  = CW'(FM_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(FM_HEIGHT - 1);
  localparam logic [PW-1:0] PARA_LAST = PW'(PARA_WORDS - 1);
  // These constants are only compared while in LEAD/HBL, which are
  // never entered when the matching interval is zero.
  localparam logic [BW-1:0] LEAD_LAST = BW'(VS_LEAD - 1);
  localparam logic [BW-1:0] HBL_LAST  = BW'(HBLANK - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PARA,
    S_VS,
    S_LEAD,
    S_ROW,
    S_HBL,
    S_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [CW-1:0] col_cnt;
  logic [RW-1:0] row_cnt;
  logic [PW-1:0] para_cnt;
  logic [BW-1:0] blank_cnt;
  logic          para_xfer;
  logic          pix_xfer;
  logic          last_col;
  logic          last_row;
  logic          last_para;

  assign last_col  = (col_cnt == COL_LAST);
  assign last_row  = (row_cnt == ROW_LAST);
  assign last_para = (para_cnt == PARA_LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: phase sequencing driven by accepted words and interval counters.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = cfg_load ? S_PARA : S_VS;
        end
      end
      S_PARA: begin
        if (para_xfer && last_para) begin
          state_nxt = S_VS;
        end
      end
      S_VS: begin
        state_nxt = (VS_LEAD == 0) ? S_ROW : S_LEAD;
      end
      S_LEAD: begin
        if (blank_cnt == LEAD_LAST) begin
          state_nxt = S_ROW;
        end
      end
      S_ROW: begin
        if (pix_xfer && last_col) begin
          if (last_row) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = (HBLANK == 0) ? S_ROW : S_HBL;
          end
        end
      end
      S_HBL: begin
        if (blank_cnt == HBL_LAST) begin
          state_nxt = S_ROW;
        end
      end
      S_DONE: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Outputs decoded from state: source readies, handshake strobes, busy.
  always_comb begin
    para_src_ready = (state == S_PARA);
    pix_src_ready  = (state == S_ROW);
    busy           = (state != S_IDLE);
    para_xfer      = para_src_valid && (state == S_PARA);
    pix_xfer       = pix_src_valid && (state == S_ROW);
  end

  // Position counters: advance only on accepted words, wrap to zero at the end of each phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_cnt   <= '0;
      row_cnt   <= '0;
      para_cnt  <= '0;
      blank_cnt <= '0;
    end else begin
      if (para_xfer) begin
        para_cnt <= last_para ? '0 : para_cnt + 1'b1;
      end
      if (pix_xfer) begin
        col_cnt <= last_col ? '0 : col_cnt + 1'b1;
        if (last_col) begin
          row_cnt <= last_row ? '0 : row_cnt + 1'b1;
        end
      end
      if ((state == S_LEAD || state == S_HBL) && state_nxt == state) begin
        blank_cnt <= blank_cnt + 1'b1;
      end else begin
        blank_cnt <= '0;
      end
    end
  end

  // Layer-side registers: data captured on transfer and held across stalls and blanking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_out       <= 1'b0;
      verticle_sync  <= 1'b0;
      data_out_valid <= 1'b0;
      para_out       <= '0;
      done           <= 1'b0;
      for (int i = 0; i < FM_DEPTH; i++) begin
        data_out[i] <= '0;
      end
    end else begin
      mode_out       <= (state == S_PARA);
      verticle_sync  <= (state == S_VS);
      data_out_valid <= para_xfer || pix_xfer;
      done           <= (state == S_DONE);
      if (para_xfer) begin
        para_out <= para_src_data;
      end
      if (pix_xfer) begin
        for (int i = 0; i < FM_DEPTH; i++) begin
          data_out[i] <= pix_src_data[i];
        end
      end
    end
  end

endmodule
